// File: rtl/ecc_mem_bit_tmr_if.sv
// Bit-cell bus: the data bit written every cycle and the voted/flagged readback.
interface ecc_mem_bit_tmr_if;
  logic inp;  // data bit written on every rising clock edge
  logic val;  // majority-voted stored bit
  logic err;  // redundant copies disagree

  // The array controller drives the data and observes the readback.
  modport master (output inp, input val, err);
  // The storage cell accepts the data and drives the readback.
  modport slave  (input inp, output val, err);
endinterface

// File: rtl/ecc_mem_bit_tmr.sv
// N-way modular-redundant single-bit storage cell (TMR by default).
// Every copy is rewritten each cycle, so upsets are scrubbed at the next edge.
// The output is the strict-majority vote of the copies. err flags any disagreement.
module ecc_mem_bit_tmr #(
  parameter int COPIES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  ecc_mem_bit_tmr_if.slave bus
);

  localparam int CNT_W = $clog2(COPIES + 1);

  // An even or too-small copy count has no strict majority to vote on.
  generate
    if ((COPIES < 3) || ((COPIES % 2) == 0)) begin : g_bad_copies
      $error("ecc_mem_bit_tmr: COPIES must be odd and >= 3");
    end
  endgenerate

  // Redundant copies must survive synthesis as distinct flops, or the hardening is lost.
  (* keep = "true", dont_touch = "true" *)
  logic [COPIES-1:0] copy_q;

  logic [CNT_W-1:0]  w_ones;
  logic              w_all_zero;
  logic              w_all_one;

  // Load the input bit into every copy each cycle; reset clears all copies at once.
  // NOTE: state is updated with non-blocking assignments so every copy samples the same pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copy_q <= '0;
    end else begin
      copy_q <= {COPIES{bus.inp}};
    end
  end

  // Count the copies holding 1, so the voter works for any legal COPIES.
  // NOTE: the accumulator starts at a default before the loop, so no latch is inferred and blocking updates chain correctly.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < COPIES; i++) begin
      w_ones = w_ones + CNT_W'(copy_q[i]);
    end
  end

  assign w_all_zero = ~|copy_q;
  assign w_all_one  = &copy_q;

  // The readback depends only on the stored copies, never directly on inp.
  assign bus.val = (w_ones > CNT_W'(COPIES / 2));
  assign bus.err = ~(w_all_zero | w_all_one);

endmodule

// File: tb/tb_ecc_mem_bit_tmr.sv
// Self-checking bench for ecc_mem_bit_tmr: a TMR instance and a 5-copy instance.
// Expected outputs come from a reference model that votes by counting ones.
module tb_ecc_mem_bit_tmr;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  ecc_mem_bit_tmr_if bus3 ();
  ecc_mem_bit_tmr_if bus5 ();

  ecc_mem_bit_tmr #(.COPIES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  ecc_mem_bit_tmr #(.COPIES(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare an observed {val,err} pair with the model's pair.
  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got val,err=%b required %b", tag, got, exp);
    end
  endtask

  // Reference model: strict majority of the copies, and disagreement flag.
  function automatic logic [1:0] model(input logic [4:0] copies, input int n);
    int   ones;
    logic all_same;
    ones     = $countones(copies) ;
    all_same = (ones == 0) || (ones == n);
    return {ones > n / 2, !all_same};
  endfunction

  // Drive a bit mid-low-phase, then sample just after the following rising edge.
  task automatic write_bit(input logic b);
    @(negedge clk);
    #2;
    bus3.inp = b;
    bus5.inp = b;
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the bench must always end by itself.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic b;
    logic [4:0] fault;

    // Reset held while clocking with inp=1: copies must stay cleared.
    rst_n    = 1'b0;
    bus3.inp = 1'b1;
    bus5.inp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_c3", {bus3.val, bus3.err}, 2'b00);
    check("reset_c5", {bus5.val, bus5.err}, 2'b00);

    // Release between edges; the next edge with inp=1 stores 1.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_c3", {bus3.val, bus3.err}, model(5'b00111, 3));
    check("post_reset_c5", {bus5.val, bus5.err}, model(5'b11111, 5));

    // Random write stream: the readback is the bit sampled at the previous edge.
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom());
      write_bit(b);
      check($sformatf("rand_c3_%0d", i), {bus3.val, bus3.err}, {b, 1'b0});
      check($sformatf("rand_c5_%0d", i), {bus5.val, bus5.err}, {b, 1'b0});
    end

    // Single upset on a stored 1, then scrubbed by the next write.
    write_bit(1'b1);
    fault = 5'b00101;
    force dut3.copy_q = fault[2:0];
    #1;
    check("single_upset", {bus3.val, bus3.err}, model(fault, 3));
    release dut3.copy_q;
    write_bit(1'b1);
    check("single_scrub", {bus3.val, bus3.err}, model(5'b00111, 3));

    // Double upset on a stored 0: wrong data, but flagged.
    write_bit(1'b0);
    fault = 5'b00101;
    force dut3.copy_q = fault[2:0];
    #1;
    check("double_upset", {bus3.val, bus3.err}, model(fault, 3));
    release dut3.copy_q;
    write_bit(1'b0);
    check("double_scrub", {bus3.val, bus3.err}, model(5'b00000, 3));

    // Five copies: two flips are corrected, a third flips the vote.
    write_bit(1'b1);
    fault = 5'b10110;
    force dut5.copy_q = fault;
    #1;
    check("c5_two_flips", {bus5.val, bus5.err}, model(fault, 5));
    fault = 5'b10100;
    force dut5.copy_q = fault;
    #1;
    check("c5_three_flips", {bus5.val, bus5.err}, model(fault, 5));
    release dut5.copy_q;
    write_bit(1'b1);
    check("c5_scrub", {bus5.val, bus5.err}, model(5'b11111, 5));

    // Asynchronous reset between edges while val=1.
    write_bit(1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_c3", {bus3.val, bus3.err}, 2'b00);
    check("async_rst_c5", {bus5.val, bus5.err}, 2'b00);
    #1;
    rst_n = 1'b1;
    write_bit(1'b1);
    check("after_async_c3", {bus3.val, bus3.err}, model(5'b00111, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
